// File: rtl/ethernet_frame_tx_pkg.sv
// eth_pkg: shared state codes, field constants and the serial CRC-32 step for the frame transmitter
package eth_pkg;
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_PRE  = 4'd1;
  localparam logic [3:0] S_SFD  = 4'd2;
  localparam logic [3:0] S_DST  = 4'd3;
  localparam logic [3:0] S_SRC  = 4'd4;
  localparam logic [3:0] S_TYPE = 4'd5;
  localparam logic [3:0] S_DATA = 4'd6;
  localparam logic [3:0] S_FCS  = 4'd7;
  localparam logic [3:0] S_IFG  = 4'd8;
  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] SFD_BYTE = 8'hAB;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam int PRE_BITS = 56;
  localparam int MAC_BITS = 48;
  localparam int TYPE_BITS = 16;
  localparam int FCS_BITS = 32;
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? CRC_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/eth_crc32_serial.sv
// eth_crc32_serial: bit-serial CRC-32 (clk, rst, clr clears, en updates with bit_in, crc holds the register)
module eth_crc32_serial
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [31:0] crc
);
  logic [31:0] crc_q, crc_d;
  always_comb crc_d = clr ? 32'h0 : en ? crc_step(crc_q, bit_in) : crc_q;
  always_ff @(posedge clk) crc_q <= rst ? 32'h0 : crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/ethernet_frame_tx.sv
// ethernet_frame_tx: serial Ethernet frame transmitter (start+header in, payload valid/ready in, tx_bit/tx_en/busy/done/err out)
module ethernet_frame_tx
  import eth_pkg::*;
#(
  parameter int MAX_LEN  = 1500,
  parameter int IFG_BITS = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] mac_dst,
  input  logic [47:0] mac_src,
  input  logic [15:0] ether_type,
  input  logic [7:0]  payload_data,
  input  logic        payload_valid,
  output logic        payload_ready,
  output logic        tx_bit,
  output logic        tx_en,
  output logic        busy,
  output logic        done,
  output logic        err
);
  logic [3:0] state_q, state_d;
  logic [15:0] cnt_q, cnt_d, acc_q, acc_d, type_q, type_d, lim;
  logic [47:0] sh_q, sh_d, src_q, src_d;
  logic [7:0] buf_q, buf_d;
  logic full_q, full_d, done_q, done_d, err_q, err_d;
  logic [31:0] crc;
  logic legal, accept, last, move, shifting, in_tx, cur_bit;
  always_comb begin
    lim = state_q == S_PRE ? 16'(PRE_BITS - 1)
        : state_q == S_SFD ? 16'd7
        : (state_q == S_DST || state_q == S_SRC) ? 16'(MAC_BITS - 1)
        : state_q == S_TYPE ? 16'(TYPE_BITS - 1)
        : state_q == S_DATA ? {type_q[12:0], 3'b000} - 16'd1
        : state_q == S_FCS ? 16'(FCS_BITS - 1)
        : 16'(IFG_BITS - 1);
    last = cnt_q == lim;
    in_tx = state_q != S_IDLE && state_q != S_IFG;
    shifting = state_q >= S_DST && state_q <= S_DATA;
    cur_bit = state_q == S_PRE ? PREAMBLE_BYTE[~cnt_q[2:0]]
            : state_q == S_SFD ? SFD_BYTE[~cnt_q[2:0]]
            : state_q == S_FCS ? crc[~cnt_q[4:0]]
            : sh_q[47];
    legal = ether_type != 16'd0 && ether_type <= 16'(MAX_LEN);
    accept = state_q == S_IDLE && start && legal;
    // the next payload byte is due at the end of TYPE and at every DATA byte boundary but the last
    move = state_q == S_TYPE ? last : state_q == S_DATA && cnt_q[2:0] == 3'd7 && !last;
  end
  assign busy = state_q != S_IDLE;
  assign tx_en = in_tx;
  assign tx_bit = in_tx & cur_bit;
  assign done = done_q;
  assign err = err_q;
  assign payload_ready = !full_q && state_q >= S_SFD && state_q <= S_DATA && acc_q < type_q;
  always_comb begin
    state_d = state_q;
    cnt_d = busy ? cnt_q + 16'd1 : 16'd0;
    sh_d = shifting ? {sh_q[46:0], 1'b0} : sh_q;
    src_d = src_q;
    type_d = type_q;
    buf_d = buf_q;
    full_d = full_q;
    acc_d = acc_q;
    done_d = 1'b0;
    err_d = state_q == S_IDLE && start && !legal;
    if (accept) begin
      state_d = S_PRE;
      sh_d = mac_dst;
      src_d = mac_src;
      type_d = ether_type;
      full_d = 1'b0;
      acc_d = 16'd0;
    end
    if (busy && last) begin
      state_d = state_q == S_IFG ? S_IDLE : state_q + 4'd1;
      cnt_d = 16'd0;
      done_d = state_q == S_FCS;
      sh_d = state_q == S_DST ? src_q : state_q == S_SRC ? {type_q, 32'h0} : sh_d;
    end
    if (payload_valid && payload_ready) begin
      buf_d = payload_data;
      full_d = 1'b1;
      acc_d = acc_q + 16'd1;
    end
    if (move && full_q) begin
      sh_d = {buf_q, 40'h0};
      full_d = 1'b0;
    end
    if (move && !full_q) begin
      state_d = S_IFG;
      cnt_d = 16'd0;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      src_q <= '0;
      type_q <= '0;
      buf_q <= '0;
      full_q <= 1'b0;
      acc_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      src_q <= src_d;
      type_q <= type_d;
      buf_q <= buf_d;
      full_q <= full_d;
      acc_q <= acc_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  eth_crc32_serial u_crc (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en(shifting),
    .bit_in(sh_q[47]),
    .crc(crc)
  );
endmodule
